rnn_forward_mul_arbiter: RTL and testbench

//   Shares one signed multiplier (A_WIDTH x B_WIDTH -> P_WIDTH) between NUM_REQ requesters
//   in the rnn_forward datapath (input-weight path, recurrent-weight path, ...).

---
 rtl/rnn_forward_mul_arbiter_if.sv | 29 ++
 rtl/rnn_forward_mul_arbiter.sv | 112 +++++++++++
 tb/tb_rnn_forward_mul_arbiter.sv | 315 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rnn_forward_mul_arbiter_if.sv
// Requester-side handshake bundle for the shared multiplier arbiter.
// The master modport is the requester side, the slave modport is the arbiter side.
interface rnn_forward_mul_arbiter_if #(
    parameter int unsigned NUM_REQ   = 2,
    parameter int unsigned A_WIDTH   = 13,
    parameter int unsigned B_WIDTH   = 71,
    parameter int unsigned P_WIDTH   = 71,
    parameter int unsigned TAG_WIDTH = 4
);
    logic [NUM_REQ-1:0]           req_valid;
    logic [NUM_REQ-1:0]           req_ready;
    logic [NUM_REQ*A_WIDTH-1:0]   req_a;
    logic [NUM_REQ*B_WIDTH-1:0]   req_b;
    logic [NUM_REQ*TAG_WIDTH-1:0] req_tag;
    logic [NUM_REQ-1:0]           res_valid;
    logic [NUM_REQ-1:0]           res_ready;
    logic [P_WIDTH-1:0]           res_p;
    logic [TAG_WIDTH-1:0]         res_tag;

    modport master (
        output req_valid, req_a, req_b, req_tag, res_ready,
        input  req_ready, res_valid, res_p, res_tag
    );

    modport slave (
        input  req_valid, req_a, req_b, req_tag, res_ready,
        output req_ready, res_valid, res_p, res_tag
    );
endinterface

// File: rtl/rnn_forward_mul_arbiter.sv
// Round-robin arbiter sharing one signed multiplier between NUM_REQ requesters;
// the product is registered in a single result slot and returned with its tag.
module rnn_forward_mul_arbiter #(
    parameter int unsigned NUM_REQ   = 2,
    parameter int unsigned A_WIDTH   = 13,
    parameter int unsigned B_WIDTH   = 71,
    parameter int unsigned P_WIDTH   = 71,
    parameter int unsigned TAG_WIDTH = 4
) (
    input  logic                     ap_clk,
    input  logic                     ap_rst_n,
    rnn_forward_mul_arbiter_if.slave bus,
    output logic                     busy,
    output logic [15:0]              grant_cnt
);
    localparam int unsigned PtrW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic {StEmpty, StFull} slot_e;

    slot_e                  state_q, state_d;
    logic [PtrW-1:0]        ptr_q, ptr_d;
    logic [PtrW-1:0]        owner_q, owner_d;
    logic [P_WIDTH-1:0]     res_p_q, res_p_d;
    logic [TAG_WIDTH-1:0]   res_tag_q, res_tag_d;
    logic [15:0]            cnt_q, cnt_d;

    logic                   can_accept;
    logic                   gnt_any;
    logic [PtrW-1:0]        gnt_idx;
    logic [PtrW-1:0]        scan_idx;
    logic signed [A_WIDTH-1:0] a_sel;
    logic signed [B_WIDTH-1:0] b_sel;
    logic [P_WIDTH-1:0]     prod;

    // Grant depends only on valids, pointer and slot state; reset forces no grant.
    always_comb begin
        can_accept = (state_q == StEmpty) || bus.res_ready[owner_q];
        gnt_any    = 1'b0;
        gnt_idx    = '0;
        scan_idx   = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            scan_idx = PtrW'((32'(ptr_q) + k) % NUM_REQ);
            if (!gnt_any && bus.req_valid[scan_idx]) begin
                gnt_any = 1'b1;
                gnt_idx = scan_idx;
            end
        end
        if (!can_accept || !ap_rst_n) begin
            gnt_any = 1'b0;
        end
        bus.req_ready = '0;
        if (gnt_any) begin
            bus.req_ready[gnt_idx] = 1'b1;
        end
    end

    // Low P_WIDTH bits only depend on operands sign-extended/truncated to P_WIDTH.
    always_comb begin
        a_sel = bus.req_a[32'(gnt_idx) * A_WIDTH +: A_WIDTH];
        b_sel = bus.req_b[32'(gnt_idx) * B_WIDTH +: B_WIDTH];
        prod  = P_WIDTH'(a_sel) * P_WIDTH'(b_sel);
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        owner_d   = owner_q;
        res_p_d   = res_p_q;
        res_tag_d = res_tag_q;
        cnt_d     = cnt_q;
        if (state_q == StFull && bus.res_ready[owner_q]) begin
            state_d = StEmpty;
        end
        if (gnt_any) begin
            state_d   = StFull;
            owner_d   = gnt_idx;
            res_p_d   = prod;
            res_tag_d = bus.req_tag[32'(gnt_idx) * TAG_WIDTH +: TAG_WIDTH];
            ptr_d     = (gnt_idx == PtrW'(NUM_REQ - 1)) ? '0 : gnt_idx + PtrW'(1);
            cnt_d     = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_q   <= StEmpty;
            ptr_q     <= '0;
            owner_q   <= '0;
            res_p_q   <= '0;
            res_tag_q <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            owner_q   <= owner_d;
            res_p_q   <= res_p_d;
            res_tag_q <= res_tag_d;
            cnt_q     <= cnt_d;
        end
    end

    always_comb begin
        bus.res_valid = '0;
        if (state_q == StFull) begin
            bus.res_valid[owner_q] = 1'b1;
        end
        bus.res_p   = res_p_q;
        bus.res_tag = res_tag_q;
        busy        = (state_q == StFull);
        grant_cnt   = cnt_q;
    end
endmodule

// File: tb/tb_rnn_forward_mul_arbiter.sv
// Bench for rnn_forward_mul_arbiter: a 2-requester instance for directed cases and a
// 4-requester instance for random fairness, both checked by a queue-based scoreboard.
module tb_rnn_forward_mul_arbiter;
    logic clk;
    logic rst_n;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive arrays, index 0 -> 2-requester DUT, index 1 -> 4-requester DUT.
    logic [3:0]   dv  [2];
    logic [51:0]  da  [2];
    logic [283:0] db  [2];
    logic [15:0]  dt  [2];
    logic [3:0]   drr [2];

    rnn_forward_mul_arbiter_if #(.NUM_REQ(2)) bus2 ();
    rnn_forward_mul_arbiter_if #(.NUM_REQ(4)) bus4 ();
    logic        busy2, busy4;
    logic [15:0] cnt2, cnt4;

    assign bus2.req_valid = dv[0][1:0];
    assign bus2.req_a     = da[0][25:0];
    assign bus2.req_b     = db[0][141:0];
    assign bus2.req_tag   = dt[0][7:0];
    assign bus2.res_ready = drr[0][1:0];
    assign bus4.req_valid = dv[1];
    assign bus4.req_a     = da[1];
    assign bus4.req_b     = db[1];
    assign bus4.req_tag   = dt[1];
    assign bus4.res_ready = drr[1];

    rnn_forward_mul_arbiter #(.NUM_REQ(2)) u_dut2 (
        .ap_clk    (clk),
        .ap_rst_n  (rst_n),
        .bus       (bus2),
        .busy      (busy2),
        .grant_cnt (cnt2)
    );

    rnn_forward_mul_arbiter #(.NUM_REQ(4)) u_dut4 (
        .ap_clk    (clk),
        .ap_rst_n  (rst_n),
        .bus       (bus4),
        .busy      (busy4),
        .grant_cnt (cnt4)
    );

    typedef struct {
        int          own;
        logic [70:0] p;
        logic [3:0]  tag;
    } exp_t;

    exp_t        sbq [2][$];
    int          mptr [2];
    logic [15:0] mcnt [2];
    logic [3:0]  hs [2];
    int          waitc [2][4];
    int          maxw [2];
    int          nerr = 0;
    int          nchk = 0;

    task automatic chk(input string nm, input logic [70:0] act, input logic [70:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            sbq[d].delete();
            mptr[d] = 0;
            mcnt[d] = '0;
            hs[d]   = '0;
            for (int i = 0; i < 4; i++) waitc[d][i] = 0;
        end
    endtask

    // Reference model: slot is full exactly when the queue holds an entry.
    task automatic sb_step(input int d, input int n, input logic [3:0] valid,
                           input logic [3:0] ready, input logic [3:0] rvalid,
                           input logic [3:0] rready, input logic [70:0] p,
                           input logic [3:0] tag, input logic busy, input logic [15:0] cnt,
                           input logic [51:0] a_f, input logic [283:0] b_f,
                           input logic [15:0] t_f);
        exp_t e;
        bit   can;
        int   g;
        int   dg;
        logic [3:0] exp_rdy;
        logic signed [12:0] sa;
        logic signed [70:0] sbv;
        logic signed [83:0] full;
        if (sbq[d].size() > 0) begin
            e = sbq[d][0];
            chk($sformatf("d%0d_res_valid", d), 71'(rvalid), 71'(4'b1 << e.own));
            chk($sformatf("d%0d_res_p", d), p, e.p);
            chk($sformatf("d%0d_res_tag", d), 71'(tag), 71'(e.tag));
        end else begin
            chk($sformatf("d%0d_res_valid_idle", d), 71'(rvalid), 71'(0));
        end
        chk($sformatf("d%0d_busy", d), 71'(busy), 71'(sbq[d].size() > 0));
        chk($sformatf("d%0d_grant_cnt", d), 71'(cnt), 71'(mcnt[d]));
        can = (sbq[d].size() == 0) || rready[sbq[d].size() > 0 ? sbq[d][0].own : 0];
        g = -1;
        for (int k = 0; k < n; k++) begin
            int idx;
            idx = (mptr[d] + k) % n;
            if (g < 0 && valid[idx]) g = idx;
        end
        if (!can) g = -1;
        exp_rdy = (g >= 0) ? (4'b1 << g) : 4'b0;
        chk($sformatf("d%0d_req_ready", d), 71'(ready), 71'(exp_rdy));
        hs[d] = valid & ready;
        dg = -1;
        for (int i = 0; i < n; i++) if (ready[i] && dg < 0) dg = i;
        for (int i = 0; i < n; i++) begin
            if (!valid[i] || i == dg) waitc[d][i] = 0;
            else if (dg >= 0) begin
                waitc[d][i]++;
                if (waitc[d][i] > maxw[d]) maxw[d] = waitc[d][i];
            end
        end
        if (sbq[d].size() > 0 && rready[sbq[d][0].own]) void'(sbq[d].pop_front());
        if (g >= 0) begin
            sa   = a_f[g*13 +: 13];
            sbv  = b_f[g*71 +: 71];
            full = 84'(sa) * 84'(sbv);
            e.own = g;
            e.p   = full[70:0];
            e.tag = t_f[g*4 +: 4];
            sbq[d].push_back(e);
            mptr[d] = (g + 1) % n;
            mcnt[d] = mcnt[d] + 16'd1;
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            sb_step(0, 2, {2'b0, bus2.req_valid}, {2'b0, bus2.req_ready},
                    {2'b0, bus2.res_valid}, {2'b0, bus2.res_ready}, bus2.res_p,
                    bus2.res_tag, busy2, cnt2, {26'b0, bus2.req_a},
                    {142'b0, bus2.req_b}, {8'b0, bus2.req_tag});
            sb_step(1, 4, bus4.req_valid, bus4.req_ready, bus4.res_valid, bus4.res_ready,
                    bus4.res_p, bus4.res_tag, busy4, cnt4, bus4.req_a, bus4.req_b,
                    bus4.req_tag);
        end
    end

    function automatic logic [70:0] rnd_b();
        logic [95:0] t;
        t = {$urandom, $urandom, $urandom};
        return t[70:0];
    endfunction

    // New operands only after a handshake, so waiting requests hold stable.
    task automatic drive_rand(input int d, input int n, input bit all_valid);
        for (int i = 0; i < n; i++) begin
            if (hs[d][i] || !dv[d][i]) begin
                dv[d][i]              = all_valid || ($urandom_range(3) != 0);
                da[d][i*13 +: 13]     = 13'($urandom);
                db[d][i*71 +: 71]     = rnd_b();
                dt[d][i*4 +: 4]       = 4'($urandom);
            end
        end
        drr[d] = 4'($urandom) | 4'($urandom);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        model_reset();
        #6 rst_n = 1'b1;
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            dv[d] = '0; da[d] = '0; db[d] = '0; dt[d] = '0; drr[d] = '0; maxw[d] = 0;
        end
        model_reset();
        rst_n = 1'b0;
        dv[0] = 4'b0011;
        dv[1] = 4'b1111;
        #3;
        chk("rst_ready2", 71'(bus2.req_ready), 71'(0));
        chk("rst_ready4", 71'(bus4.req_ready), 71'(0));
        chk("rst_res_valid", 71'(bus2.res_valid), 71'(0));
        chk("rst_res_p", bus2.res_p, 71'(0));
        chk("rst_tag_busy_cnt", 71'({bus2.res_tag, busy2, cnt2}), 71'(0));
        dv[0] = '0;
        dv[1] = '0;
        #9 rst_n = 1'b1;

        // Single request with small signed operands.
        tick();
        dv[0] = 4'b0001; da[0][12:0] = 13'h1FFD; db[0][70:0] = 71'd5; dt[0][3:0] = 4'd7;
        drr[0] = '0;
        @(negedge clk);
        chk("t1_ready", 71'(bus2.req_ready), 71'(2'b01));
        tick();
        dv[0] = '0;
        @(negedge clk);
        chk("t1_res_valid", 71'(bus2.res_valid), 71'(2'b01));
        chk("t1_res_p", bus2.res_p, 71'(-15));
        chk("t1_res_tag", 71'(bus2.res_tag), 71'(7));
        chk("t1_cnt", 71'(cnt2), 71'(1));
        drr[0] = 4'b0011;
        tick();

        // Both requesters continuously valid, results drained every cycle.
        do_reset();
        dv[0] = 4'b0011;
        for (int i = 0; i < 2; i++) begin
            da[0][i*13 +: 13] = 13'($urandom);
            db[0][i*71 +: 71] = rnd_b();
            dt[0][i*4 +: 4]   = 4'($urandom);
        end
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            chk("t2_order", 71'(bus2.req_ready), 71'(2'b01 << (k % 2)));
            tick();
            da[0][(k%2)*13 +: 13] = 13'($urandom);
            db[0][(k%2)*71 +: 71] = rnd_b();
            dt[0][(k%2)*4 +: 4]   = 4'($urandom);
        end
        dv[0] = '0;
        @(negedge clk);
        chk("t2_cnt", 71'(cnt2), 71'(100));

        // Owner stalls for three cycles; slot must hold and block grants.
        tick();
        drr[0] = '0;
        dv[0] = 4'b0001; da[0][12:0] = 13'd123; db[0][70:0] = 71'(-77); dt[0][3:0] = 4'd9;
        @(negedge clk);
        chk("t3_first_ready", 71'(bus2.req_ready), 71'(2'b01));
        tick();
        dv[0] = 4'b0011;
        da[0][12:0] = 13'd55; db[0][70:0] = 71'd3; dt[0][3:0] = 4'd2;
        da[0][25:13] = 13'd11; db[0][141:71] = 71'd6; dt[0][7:4] = 4'd4;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("t3_stall_ready", 71'(bus2.req_ready), 71'(0));
            chk("t3_stall_p", bus2.res_p, 71'(-9471));
            chk("t3_stall_tag", 71'(bus2.res_tag), 71'(9));
            tick();
        end
        drr[0] = 4'b0001;
        @(negedge clk);
        chk("t3_release_ready", 71'(bus2.req_ready), 71'(2'b10));
        tick();
        dv[0] = 4'b0001;
        drr[0] = 4'b0011;
        @(negedge clk);
        tick();
        dv[0] = '0;
        @(negedge clk);
        tick();

        // Two's-complement wrap of the truncated product.
        dv[0] = 4'b0001; da[0][12:0] = 13'h1000; db[0][70:0] = {1'b0, {70{1'b1}}};
        dt[0][3:0] = 4'd1;
        @(negedge clk);
        tick();
        da[0][12:0] = 13'd1; db[0][70:0] = '1; dt[0][3:0] = 4'd2;
        @(negedge clk);
        chk("t4_wrap_p", bus2.res_p, 71'd4096);
        tick();
        dv[0] = '0;
        @(negedge clk);
        chk("t4_ones_p", bus2.res_p, {71{1'b1}});
        tick();

        // Asynchronous reset while requester 1 owns a held result.
        dv[0] = 4'b0010; da[0][25:13] = 13'($urandom); db[0][141:71] = rnd_b();
        dt[0][7:4] = 4'd5; drr[0] = '0;
        tick();
        dv[0] = '0;
        @(negedge clk);
        chk("t5_held", 71'(bus2.res_valid), 71'(2'b10));
        #2 rst_n = 1'b0;
        model_reset();
        dv[0] = 4'b0011;
        #1;
        chk("t5_rst_res_valid", 71'(bus2.res_valid), 71'(0));
        chk("t5_rst_cnt", 71'(cnt2), 71'(0));
        chk("t5_rst_ready", 71'(bus2.req_ready), 71'(0));
        #4 rst_n = 1'b1;
        #1;
        chk("t5_first_grant", 71'(bus2.req_ready), 71'(2'b01));

        // Random traffic on both instances, first half with every requester valid.
        for (int k = 0; k < 3000; k++) begin
            tick();
            drive_rand(0, 2, 1'b0);
            drive_rand(1, 4, k < 1500);
        end
        tick();
        dv[0] = '0; dv[1] = '0; drr[0] = 4'hF; drr[1] = 4'hF;
        repeat (4) tick();
        @(negedge clk);
        chk("fair2", 71'(maxw[0] <= 1), 71'(1));
        chk("fair4", 71'(maxw[1] <= 3), 71'(1));
        chk("drained", 71'(sbq[0].size() + sbq[1].size()), 71'(0));
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
